// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter: FSM state encoding and parity modes.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: counts 0..BAUD_DIVIDER-1 while enabled, pulses tick on the last count.
module baud_tick_gen #(
    parameter int BAUD_DIVIDER = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam logic [15:0] LAST_CNT = 16'(BAUD_DIVIDER - 1);

    logic [15:0] cnt;

    assign tick = enable && (cnt == LAST_CNT);

    // Held at zero while disabled so every frame starts on a full bit period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!enable || cnt == LAST_CNT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/serial_tx_fifo.sv
// UART-style serial transmitter fed by a small write FIFO; frames go out back-to-back
// while words are queued.
module serial_tx_fifo #(
    parameter int BAUD_DIVIDER = 104,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          data,
    input  logic                          save_data,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic                          TiP,
    output logic                          tx
);
    import serial_pkg::*;

    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0]      LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]      LAST_STOP = 4'(STOP_BITS - 1);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 wr_en, pop, shift_en, tick, tx_nx;
    tx_state_t            state, state_nx;
    logic [3:0]           bit_cnt, bit_cnt_nx;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;

    function automatic logic calc_parity(input logic [DATA_BITS-1:0] w);
        calc_parity = (PARITY == PAR_ODD) ? ~(^w) : (^w);
    endfunction

    assign full       = (count == DEPTH_CNT);
    assign fifo_count = count;
    assign wr_en      = save_data && !full;

    baud_tick_gen #(.BAUD_DIVIDER(BAUD_DIVIDER)) u_baud (
        .clk    (clk),
        .rst    (rst),
        .enable (state != ST_IDLE),
        .tick   (tick)
    );

    // FIFO control; full is taken from the pre-edge count, so a same-edge pop cannot rescue a write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (save_data && full) overrun <= 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= data;
    end

    // Next-state and next-output; tx is registered from tx_nx to stay glitch-free
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        tx_nx      = tx;
        pop        = 1'b0;
        shift_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                tx_nx = 1'b1;
                if (count != '0) begin
                    pop        = 1'b1;
                    state_nx   = ST_START;
                    bit_cnt_nx = '0;
                    tx_nx      = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_nx = ST_DATA;
                    tx_nx    = shift_q[0];
                    shift_en = 1'b1;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt_nx = '0;
                        if (PARITY != PAR_NONE) begin
                            state_nx = ST_PARITY;
                            tx_nx    = par_q;
                        end else begin
                            state_nx = ST_STOP;
                            tx_nx    = 1'b1;
                        end
                    end else begin
                        bit_cnt_nx = bit_cnt + 4'd1;
                        tx_nx      = shift_q[0];
                        shift_en   = 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_nx = ST_STOP;
                    tx_nx    = 1'b1;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_cnt == LAST_STOP) begin
                        bit_cnt_nx = '0;
                        if (count != '0) begin
                            pop      = 1'b1;
                            state_nx = ST_START;
                            tx_nx    = 1'b0;
                        end else begin
                            state_nx = ST_IDLE;
                            tx_nx    = 1'b1;
                        end
                    end else begin
                        bit_cnt_nx = bit_cnt + 4'd1;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
                tx_nx    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            tx      <= 1'b1;
            TiP     <= 1'b0;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            tx      <= tx_nx;
            TiP     <= (state_nx != ST_IDLE);
        end
    end

    // Popped word is copied out of the FIFO, so later writes into its slot cannot disturb it
    always_ff @(posedge clk) begin
        if (pop) begin
            shift_q <= mem[rd_ptr];
            par_q   <= calc_parity(mem[rd_ptr]);
        end else if (shift_en) begin
            shift_q <= shift_q >> 1;
        end
    end

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Bench for serial_tx_fifo: three configurations driven in parallel, checked every cycle
// against a frame-level reference model plus directed checks.
module tb_serial_tx_fifo;

    localparam int N = 3;
    int baud_c [N] = '{4, 4, 3};
    int db_c   [N] = '{8, 7, 8};
    int par_c  [N] = '{0, 2, 1};
    int sb_c   [N] = '{1, 2, 1};
    int dep_c  [N] = '{4, 4, 2};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sd  = 1'b0;
    logic [8:0] din = '0;

    always #5 clk = ~clk;

    logic       full_a, ovr_a, tip_a, tx_a;
    logic       full_b, ovr_b, tip_b, tx_b;
    logic       full_c, ovr_c, tip_c, tx_c;
    logic [2:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    serial_tx_fifo #(.BAUD_DIVIDER(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .data(din[7:0]), .save_data(sd), .full(full_a),
        .fifo_count(cnt_a), .overrun(ovr_a), .TiP(tip_a), .tx(tx_a));
    serial_tx_fifo #(.BAUD_DIVIDER(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .data(din[6:0]), .save_data(sd), .full(full_b),
        .fifo_count(cnt_b), .overrun(ovr_b), .TiP(tip_b), .tx(tx_b));
    serial_tx_fifo #(.BAUD_DIVIDER(3), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(2)) dut_c (
        .clk(clk), .rst(rst), .data(din[7:0]), .save_data(sd), .full(full_c),
        .fifo_count(cnt_c), .overrun(ovr_c), .TiP(tip_c), .tx(tx_c));

    logic       obs_tx [N], obs_tip [N], obs_full [N], obs_ovr [N];
    logic [6:0] obs_cnt [N];
    assign obs_tx[0] = tx_a;   assign obs_tx[1] = tx_b;   assign obs_tx[2] = tx_c;
    assign obs_tip[0] = tip_a; assign obs_tip[1] = tip_b; assign obs_tip[2] = tip_c;
    assign obs_full[0] = full_a; assign obs_full[1] = full_b; assign obs_full[2] = full_c;
    assign obs_ovr[0] = ovr_a; assign obs_ovr[1] = ovr_b; assign obs_ovr[2] = ovr_c;
    assign obs_cnt[0] = {4'b0, cnt_a};
    assign obs_cnt[1] = {4'b0, cnt_b};
    assign obs_cnt[2] = {5'b0, cnt_c};

    // Reference model: a queue of accepted words plus the frame currently on the line
    int          mq [N][64];
    int          mh [N], mc [N], mt [N], flen [N];
    bit          busy [N], movr [N];
    logic [15:0] fb [N];

    int compared   = 0;
    int mismatched = 0;

    function automatic logic [15:0] build_frame(input int i, input logic [8:0] w);
        logic [15:0] f;
        logic        p;
        f    = '1;
        f[0] = 1'b0;
        p    = 1'b0;
        for (int b = 0; b < db_c[i]; b++) begin
            f[1+b] = w[b];
            p      = p ^ w[b];
        end
        if (par_c[i] == 2)      f[1+db_c[i]] = p;
        else if (par_c[i] == 1) f[1+db_c[i]] = ~p;
        return f;
    endfunction

    function void model_reset();
        for (int i = 0; i < N; i++) begin
            mh[i] = 0; mc[i] = 0; mt[i] = 0; busy[i] = 1'b0; movr[i] = 1'b0;
        end
    endfunction

    function void model_edge(input logic s, input logic [8:0] d);
        for (int i = 0; i < N; i++) begin
            int         pre;
            bit         do_pop;
            logic [8:0] w;
            pre    = mc[i];
            do_pop = 1'b0;
            if (busy[i]) begin
                mt[i]++;
                if (mt[i] == flen[i]) begin
                    if (pre > 0) do_pop = 1'b1;
                    else         busy[i] = 1'b0;
                end
            end else if (pre > 0) begin
                do_pop = 1'b1;
            end
            if (s) begin
                if (pre == dep_c[i]) movr[i] = 1'b1;
                else begin
                    mq[i][(mh[i] + mc[i]) % 64] = int'(d) & ((1 << db_c[i]) - 1);
                    mc[i]++;
                end
            end
            if (do_pop) begin
                w       = 9'(mq[i][mh[i]]);
                mh[i]   = (mh[i] + 1) % 64;
                mc[i]--;
                fb[i]   = build_frame(i, w);
                mt[i]   = 0;
                busy[i] = 1'b1;
            end
        end
    endfunction

    task automatic chk(input string tag, input int i, input logic [6:0] obs, input logic [6:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s[%0d] observed=0x%0h expected=0x%0h at %0t", tag, i, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            logic exp_tx;
            exp_tx = busy[i] ? fb[i][mt[i] / baud_c[i]] : 1'b1;
            chk("tx",         i, {6'b0, obs_tx[i]},   {6'b0, exp_tx});
            chk("tip",        i, {6'b0, obs_tip[i]},  {6'b0, busy[i]});
            chk("fifo_count", i, obs_cnt[i],          7'(mc[i]));
            chk("full",       i, {6'b0, obs_full[i]}, {6'b0, (mc[i] == dep_c[i])});
            chk("overrun",    i, {6'b0, obs_ovr[i]},  {6'b0, movr[i]});
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(sd, din);
        #1;
        check_all();
    endtask

    task automatic async_reset_pulse();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        step();
        #2 rst = 1'b0;
    endtask

    initial begin
        int tipcnt;
        for (int i = 0; i < N; i++)
            flen[i] = (1 + db_c[i] + ((par_c[i] != 0) ? 1 : 0) + sb_c[i]) * baud_c[i];
        model_reset();

        // Reset state
        repeat (3) step();
        #2 rst = 1'b0;

        // 8N1 0x55 single frame: TiP high for 40 cycles
        sd = 1'b1; din = 9'h055;
        step();
        sd = 1'b0;
        tipcnt = 0;
        repeat (50) begin
            step();
            tipcnt += int'(tip_a);
        end
        chk("tip_len_8n1", 0, 7'(tipcnt), 7'd40);

        // 7E2 0x03 single frame: 44 cycles
        sd = 1'b1; din = 9'h003;
        step();
        sd = 1'b0;
        tipcnt = 0;
        repeat (50) begin
            step();
            tipcnt += int'(tip_b);
        end
        chk("tip_len_7e2", 1, 7'(tipcnt), 7'd44);

        // Six back-to-back writes into a depth-4 FIFO
        for (int k = 0; k < 6; k++) begin
            sd = 1'b1; din = 9'($urandom_range(0, 511));
            step();
        end
        sd = 1'b0;
        chk("burst_count",   0, {4'b0, cnt_a}, 7'd4);
        chk("burst_full",    0, {6'b0, full_a}, 7'd1);
        chk("burst_overrun", 0, {6'b0, ovr_a}, 7'd1);
        repeat (260) step();

        // Reset during bit 3 of the first frame with two words queued
        async_reset_pulse();
        for (int k = 0; k < 3; k++) begin
            sd = 1'b1; din = 9'($urandom_range(0, 511));
            step();
        end
        sd = 1'b0;
        repeat (12) step();
        #2 rst = 1'b1;
        #1;
        chk("rst_tx",    0, {6'b0, tx_a},  7'd1);
        chk("rst_tip",   0, {6'b0, tip_a}, 7'd0);
        chk("rst_count", 0, {4'b0, cnt_a}, 7'd0);
        model_reset();
        check_all();
        step();
        #2 rst = 1'b0;
        repeat (60) step();

        // Randomized traffic with occasional asynchronous resets
        for (int k = 0; k < 3000; k++) begin
            sd  = ($urandom_range(0, 99) < 30);
            din = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 999) == 0) begin
                sd = 1'b0;
                async_reset_pulse();
            end else begin
                step();
            end
        end
        sd = 1'b0;
        repeat (300) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
